// File: rtl/regfile_pkg.sv
`default_nettype none
// ============================================================================
// Module      : regfile_pkg
// Description : Shared types and constants for the register-file write
//               arbiter slice (address/data widths, writeback request
//               bundle, round-robin priority encoding).
// Revision    : 1.0 - initial release
// ============================================================================
package regfile_pkg;

  localparam int NUM_REGS   = 16;
  localparam int REG_ADDR_W = 4;
  localparam int DATA_W     = 32;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

  typedef struct packed {
    logic              valid;
    reg_addr_t         addr;
    logic [DATA_W-1:0] data;
  } wb_req_t;

  // Which requester currently holds priority when both are valid
  typedef enum logic [0:0] {
    PRI_REQ0 = 1'b0,
    PRI_REQ1 = 1'b1
  } rr_pri_e;

endpackage
`default_nettype wire

// File: rtl/regfile_write_arbiter_rr_arbiter2.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter2
// Description : Two-input round-robin arbiter. Priority passes to the other
//               requester only when the current priority holder is granted.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter2
  import regfile_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  rr_pri_e r_pri;
  rr_pri_e w_pri_next;

  // Priority pointer register; reset hands priority to requester 0
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_pri <= PRI_REQ0;
    else      r_pri <= w_pri_next;
  end

  // Grant selection and pointer advance
  always_comb begin
    gnt        = 2'b00;
    w_pri_next = r_pri;
    if (req == 2'b11) gnt = (r_pri == PRI_REQ0) ? 2'b01 : 2'b10;
    else              gnt = req;
    if ((r_pri == PRI_REQ0 && gnt[0]) || (r_pri == PRI_REQ1 && gnt[1]))
      w_pri_next = (r_pri == PRI_REQ0) ? PRI_REQ1 : PRI_REQ0;
  end

endmodule
`default_nettype wire

// File: rtl/regfile_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : regfile_write_arbiter
// Description : Shares the register-file write port between the ALU and LSU
//               writeback paths (round-robin, one registered write stage) and
//               keeps a per-register busy scoreboard for RAW hazard flags.
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_write_arbiter #(
  parameter int NUM_REGS    = 16,
  parameter int DATA_W      = 32,
  parameter bit HARDWIRE_R0 = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req0_valid,
  output logic                  req0_ready,
  input  regfile_pkg::reg_addr_t req0_addr,
  input  logic [DATA_W-1:0]     req0_data,
  input  logic                  req1_valid,
  output logic                  req1_ready,
  input  regfile_pkg::reg_addr_t req1_addr,
  input  logic [DATA_W-1:0]     req1_data,
  input  logic                  reserve_valid,
  input  regfile_pkg::reg_addr_t reserve_addr,
  input  regfile_pkg::reg_addr_t rd_reg1,
  input  regfile_pkg::reg_addr_t rd_reg2,
  output logic                  hazard1,
  output logic                  hazard2,
  output logic [NUM_REGS-1:0]   busy,
  output logic                  reg_write,
  output regfile_pkg::reg_addr_t wr_reg,
  output logic [DATA_W-1:0]     wr_data,
  output logic                  err_double_reserve
);

  import regfile_pkg::reg_addr_t;

  logic [1:0]          w_req;
  logic [1:0]          w_gnt;
  reg_addr_t           w_sel_addr;
  logic [DATA_W-1:0]   w_sel_data;
  logic                w_commit;
  logic [NUM_REGS-1:0] w_clr;
  logic [NUM_REGS-1:0] w_set;
  logic                w_double;

  assign w_req = {req1_valid, req0_valid};

  rr_arbiter2 u_arb (
    .clk (clk),
    .rst (rst),
    .req (w_req),
    .gnt (w_gnt)
  );

  // A grant is the handshake; the register file never stalls
  assign req0_ready = w_gnt[0];
  assign req1_ready = w_gnt[1];

  // Winner's payload; a grant to address 0 is swallowed when r0 is hardwired
  always_comb begin
    w_sel_addr = w_gnt[1] ? req1_addr : req0_addr;
    w_sel_data = w_gnt[1] ? req1_data : req0_data;
    w_commit   = (|w_gnt) && !(HARDWIRE_R0 && (w_sel_addr == '0));
  end

  // Write stage: one-cycle pulse per grant, address/data hold when idle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      reg_write <= 1'b0;
      wr_reg    <= '0;
      wr_data   <= '0;
    end else begin
      reg_write <= w_commit;
      if (w_commit) begin
        wr_reg  <= w_sel_addr;
        wr_data <= w_sel_data;
      end
    end
  end

  // Scoreboard masks: commit clears, reservation sets and wins a tie
  always_comb begin
    w_clr    = reg_write ? (NUM_REGS'(1) << wr_reg) : '0;
    w_set    = reserve_valid ? (NUM_REGS'(1) << reserve_addr) : '0;
    w_double = reserve_valid && busy[reserve_addr] && !w_clr[reserve_addr];
  end

  // Busy vector and sticky double-reservation flag
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy               <= '0;
      err_double_reserve <= 1'b0;
    end else begin
      busy <= (busy & ~w_clr) | w_set;
      if (w_double) err_double_reserve <= 1'b1;
    end
  end

  // Hazards read the scoreboard directly; no bypass from the write stage
  assign hazard1 = busy[rd_reg1];
  assign hazard2 = busy[rd_reg2];

endmodule
`default_nettype wire

// File: tb/tb_regfile_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_regfile_write_arbiter
// Description : Self-checking bench for regfile_write_arbiter. Two instances
//               (r0 normal / r0 hardwired) share stimulus; a behavioural model
//               predicts grants, scoreboard state and the write stream.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_write_arbiter;
  import regfile_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic req0_valid = 1'b0, req1_valid = 1'b0, reserve_valid = 1'b0;
  reg_addr_t req0_addr = '0, req1_addr = '0, reserve_addr = '0, rd_reg1 = '0, rd_reg2 = '0;
  logic [31:0] req0_data = '0, req1_data = '0;

  logic [1:0]  req0_ready, req1_ready, hazard1, hazard2, reg_write, err_double_reserve;
  logic [15:0] busy    [2];
  reg_addr_t   wr_reg  [2];
  logic [31:0] wr_data [2];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    regfile_write_arbiter #(.NUM_REGS(16), .DATA_W(32), .HARDWIRE_R0(g == 1)) u_dut (
      .clk(clk), .rst(rst),
      .req0_valid(req0_valid), .req0_ready(req0_ready[g]), .req0_addr(req0_addr), .req0_data(req0_data),
      .req1_valid(req1_valid), .req1_ready(req1_ready[g]), .req1_addr(req1_addr), .req1_data(req1_data),
      .reserve_valid(reserve_valid), .reserve_addr(reserve_addr),
      .rd_reg1(rd_reg1), .rd_reg2(rd_reg2), .hazard1(hazard1[g]), .hazard2(hazard2[g]),
      .busy(busy[g]), .reg_write(reg_write[g]), .wr_reg(wr_reg[g]), .wr_data(wr_data[g]),
      .err_double_reserve(err_double_reserve[g])
    );
  end

  always #5 clk = ~clk;

  // Reference model state
  int        pri;          // requester holding priority
  bit [15:0] m_busy [2];
  bit        m_err  [2];
  bit        pend_v [2];   // a write commits on the current cycle
  int        pend_a;
  typedef struct { reg_addr_t addr; logic [31:0] data; int stamp; } exp_t;
  exp_t exp_q[$];

  int n_cmp = 0, n_bad = 0, cyc = 0;

  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    pri = 0; pend_v[0] = 0; pend_v[1] = 0; pend_a = 0;
    for (int h = 0; h < 2; h++) begin m_busy[h] = '0; m_err[h] = 0; end
    exp_q.delete();
  endtask

  // One cycle: apply inputs, check combinational and state outputs, advance model
  task automatic step(input bit v0, input reg_addr_t a0, input logic [31:0] d0,
                      input bit v1, input reg_addr_t a1, input logic [31:0] d1,
                      input bit rv, input reg_addr_t ra, input reg_addr_t r1, input reg_addr_t r2);
    int win;
    bit [15:0] old, clr;
    reg_addr_t wa;
    @(negedge clk);
    req0_valid = v0; req0_addr = a0; req0_data = d0;
    req1_valid = v1; req1_addr = a1; req1_data = d1;
    reserve_valid = rv; reserve_addr = ra; rd_reg1 = r1; rd_reg2 = r2;
    #2;
    win = -1;
    if (v0 && v1) win = pri;
    else if (v0)  win = 0;
    else if (v1)  win = 1;
    for (int h = 0; h < 2; h++) begin
      chk($sformatf("req0_ready[%0d]", h), req0_ready[h], win == 0);
      chk($sformatf("req1_ready[%0d]", h), req1_ready[h], win == 1);
      chk($sformatf("hazard1[%0d]", h), hazard1[h], m_busy[h][r1]);
      chk($sformatf("hazard2[%0d]", h), hazard2[h], m_busy[h][r2]);
      chk($sformatf("busy[%0d]", h), busy[h], m_busy[h]);
      chk($sformatf("err[%0d]", h), err_double_reserve[h], m_err[h]);
      chk($sformatf("reg_write[%0d]", h), reg_write[h], pend_v[h]);
    end
    // State after the coming rising edge
    for (int h = 0; h < 2; h++) begin
      old = m_busy[h];
      clr = pend_v[h] ? (16'(1) << pend_a) : 16'h0;
      if (rv && old[ra] && !clr[ra]) m_err[h] = 1;
      m_busy[h] = (old & ~clr) | (rv ? (16'(1) << ra) : 16'h0);
    end
    if (win >= 0) begin
      wa = (win == 1) ? a1 : a0;
      pend_a = wa; pend_v[0] = 1; pend_v[1] = (wa != 0);
      exp_q.push_back('{wa, (win == 1) ? d1 : d0, cyc + 1});
      if (win == pri) pri = 1 - pri;
    end else begin
      pend_v[0] = 0; pend_v[1] = 0;
    end
  endtask

  task automatic idle(input reg_addr_t r1, input reg_addr_t r2);
    step(0, 0, 0, 0, 0, 0, 0, 0, r1, r2);
  endtask

  task automatic check_reset_state(input string tag);
    for (int h = 0; h < 2; h++) begin
      chk($sformatf("%s busy[%0d]", tag, h), busy[h], 16'h0);
      chk($sformatf("%s reg_write[%0d]", tag, h), reg_write[h], 1'b0);
      chk($sformatf("%s wr_reg[%0d]", tag, h), wr_reg[h], 4'h0);
      chk($sformatf("%s wr_data[%0d]", tag, h), wr_data[h], 32'h0);
      chk($sformatf("%s err[%0d]", tag, h), err_double_reserve[h], 1'b0);
    end
  endtask

  // Monitor: every write pulse must match the oldest expected write, on time
  initial begin
    exp_t e;
    forever begin
      @(posedge clk); #1;
      if (rst && reg_write[0]) begin
        if (exp_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL unexpected_write: got wr_reg %0d, expected no write at %0t", wr_reg[0], $time);
        end else begin
          e = exp_q.pop_front();
          chk("wr_reg", wr_reg[0], e.addr);
          chk("wr_data", wr_data[0], e.data);
          chk("write_cycle", cyc, e.stamp);
        end
      end
    end
  end

  initial begin
    model_reset();
    #1 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1 check_reset_state("por");
    @(negedge clk) rst = 1'b1;

    // Contention: grants alternate 0,1,0,1 -> wr_reg 1,2,1,2
    for (int i = 0; i < 4; i++) step(1, 1, 32'h1000 + i, 1, 2, 32'h2000 + i, 0, 0, 0, 0);
    // Single request
    step(1, 3, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0, 0);
    idle(0, 0); idle(0, 0);
    // Reserve 5, LSU commits 5: hazard held through the write cycle
    step(0, 0, 0, 0, 0, 0, 1, 5, 5, 0);
    step(0, 0, 0, 1, 5, 32'h55, 0, 0, 5, 5);
    idle(5, 5); idle(5, 5);
    // Reserve and commit on 7 together, then double reserve
    step(0, 0, 0, 0, 0, 0, 1, 7, 7, 0);
    step(1, 7, 32'h77, 0, 0, 0, 0, 0, 7, 0);
    step(0, 0, 0, 0, 0, 0, 1, 7, 7, 0);
    idle(7, 0);
    step(0, 0, 0, 0, 0, 0, 1, 7, 7, 0);
    idle(7, 0); idle(7, 0);
    // Address 0 write: dropped by the hardwired instance
    step(0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    step(1, 0, 32'h1, 0, 0, 0, 0, 0, 0, 0);
    idle(0, 0); idle(0, 0);
    // Build busy = 00F0 then reset asynchronously mid-cycle
    step(0, 0, 0, 0, 0, 0, 1, 4, 0, 0);
    step(0, 0, 0, 0, 0, 0, 1, 5, 0, 0);
    step(0, 0, 0, 0, 0, 0, 1, 6, 0, 0);
    step(1, 9, 32'h99, 0, 0, 0, 0, 0, 4, 5);
    @(negedge clk);
    req0_valid = 0; req1_valid = 0; reserve_valid = 0;
    #2 rst = 1'b0;
    #1 check_reset_state("async_rst");
    model_reset();
    @(negedge clk); @(negedge clk) rst = 1'b1;

    // Randomised traffic
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 1), 4'($urandom_range(0, 15)), $urandom,
           $urandom_range(0, 1), 4'($urandom_range(0, 15)), $urandom,
           ($urandom_range(0, 3) == 0), 4'($urandom_range(0, 15)),
           4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
    idle(0, 0); idle(0, 0); idle(0, 0);
    chk("writes_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/regfile_write_arbiter.md
Name: regfile_write_arbiter

Overview:
- Shares the single write port of the 16 x 32-bit register file between two writeback requesters: requester 0 (ALU) and requester 1 (load/store unit).
- Each requester uses a valid/ready handshake. Arbitration is round-robin, and the winner's write is registered onto the register-file write port.
- A per-register busy scoreboard (reserve at issue, clear at commit) provides read-after-write hazard flags for the two register-file read addresses.

Parameters:
- NUM_REGS, 16, number of architectural registers; the address width is 4 bits.
- DATA_W, 32, register data width.
- HARDWIRE_R0, 0, when 1, writes to address 0 are accepted and dropped: no reg_write pulse and no busy clear.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset rst, asynchronous, active-low.
- req0_valid  input  1  ALU writeback request.
- req0_ready  output  1  ALU request granted this cycle.
- req0_addr  input  4  ALU destination register.
- req0_data  input  DATA_W  ALU result.
- req1_valid  input  1  LSU writeback request.
- req1_ready  output  1  LSU request granted this cycle.
- req1_addr  input  4  LSU destination register.
- req1_data  input  DATA_W  load data.
- reserve_valid  input  1  issue stage reserves a destination.
- reserve_addr  input  4  register being reserved.
- rd_reg1  input  4  read address 1 (same value driven to the register file).
- rd_reg2  input  4  read address 2.
- hazard1  output  1  busy[rd_reg1], combinational.
- hazard2  output  1  busy[rd_reg2], combinational.
- busy  output  NUM_REGS  scoreboard vector.
- reg_write  output  1  register-file write enable.
- wr_reg  output  4  register-file write address.
- wr_data  output  DATA_W  register-file write data.
- err_double_reserve  output  1  sticky protocol-error flag.

Behaviour:
- Reset (rst=0, asynchronous):
  - reg_write=0, wr_reg=0, wr_data=0.
  - busy=0, err_double_reserve=0.
  - Round-robin pointer set so that requester 0 has priority.
  - Everything is held while rst=0; the block resumes at the first rising edge after deassertion.
  - A request in flight when reset asserts is lost. Requesters must re-present it.
- Arbitration (combinational, cycle N):
  - Exactly one valid: that requester is granted.
  - Both valid: the priority requester is granted. Priority toggles to the other requester only when the current priority holder is granted.
  - readyX is asserted only together with validX.
  - There is no backpressure from the register file, so a grant always transfers.
- Write stage (one register):
  - On the edge ending cycle N, if a grant occurred: reg_write=1, wr_reg=addr, wr_data=data for cycle N+1 exactly. Otherwise reg_write=0.
  - wr_reg and wr_data hold their last values when idle.
  - Latency from valid to reg_write is 1 cycle. Back-to-back grants give a continuous reg_write stream.
- Same-address conflict: if both requesters target the same register, both are written in grant order. The last granted value persists. Requesters must not depend on any other order.
- HARDWIRE_R0=1 and a granted write to address 0: the requester gets ready, reg_write stays 0, and busy[0] is untouched.
- Scoreboard, evaluated on each rising edge:
  - Clear: busy[wr_reg] is cleared when reg_write=1.
  - Set: busy[reserve_addr] is set when reserve_valid=1.
  - The same register set and cleared on one edge ends busy=1 (reserve wins: a new write is in flight).
  - Reserving an already-busy register that is not being cleared on that edge keeps busy=1 and sets err_double_reserve. The flag stays set until reset.
  - A write without a prior reservation is legal and leaves busy=0.
- Hazards:
  - hazard1 and hazard2 are combinational from busy and the read addresses.
  - They stay high through cycle N+1, while reg_write is active, and fall the cycle after commit.
  - No bypass is performed.

Decomposition:
- Shared package regfile_pkg:
  - Constants NUM_REGS=16, REG_ADDR_W=4, DATA_W=32.
  - Typedef reg_addr_t (4-bit).
  - Typedef wb_req_t {valid, addr, data}.
- Sub-module rr_arbiter2: 2-input round-robin with pointer state, inputs req[1:0], outputs gnt[1:0].
- Scoreboard and write stage stay inline.

Test Plan:
- Reset: rst low mid-run with busy=16'h00F0 -> busy=0, reg_write=0, wr_reg=0, wr_data=0 immediately (asynchronous), with no clock edge needed.
- Single request: req0 addr=3 data=32'hDEADBEEF -> req0_ready same cycle; next cycle reg_write=1, wr_reg=3, wr_data=32'hDEADBEEF; the following cycle reg_write=0.
- Contention: both requesters valid for 4 cycles (addr 1 and 2) -> grants 0,1,0,1. reg_write is continuous and wr_reg sequence is 1,2,1,2.
- Scoreboard: reserve 5 -> busy[5]=1, hazard1=1 with rd_reg1=5. Then req1 writes 5 -> hazard1 stays 1 through the reg_write cycle and is 0 the cycle after.
- Simultaneous reserve and commit on register 7 -> busy[7]=1 and err_double_reserve=0. Then reserve 7 again with no commit -> err_double_reserve=1, and it stays 1 until reset.
- HARDWIRE_R0=1, req0 addr=0 data=32'h1 -> req0_ready=1, reg_write stays 0, busy unchanged.
